alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 4, datapath width; all data ports and arithmetic are WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  instruction present on in_op/in_rd/in_rs1/in_rs2.
REQ-005 in_ready  output  1  block can accept; an instruction is accepted on a rising edge where in_valid && in_ready.
REQ-006 in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 LI, 111 MUL.
REQ-007 in_rd / in_rs1 / in_rs2  input  3 each  destination, source 1, source 2 register indices.
REQ-008 rf_raddr1 / rf_raddr2  output  3 each  register-file read addresses.
REQ-009 rf_rdata1 / rf_rdata2  input  WIDTH each  register-file asynchronous read data.
REQ-010 wb_we / wb_reg / wb_data  output  1 / 3 / WIDTH  write-back port to the register file, registered.
REQ-011 carry  output  1  carry/borrow flag, registered.
REQ-012 busy  output  1  high while a MUL is in progress.

Function
REQ-013 rf_raddr1 = in_rs1 and rf_raddr2 = in_rs2 at all times (combinational).
REQ-014 Operand x (x=1,2) = wb_data if wb_we && wb_reg == in_rsx, else rf_rdataX (forwarding of the pending write-back).
REQ-015 State machine: IDLE, MUL; in_ready = (state == IDLE); busy = (state == MUL).
REQ-016 Single-cycle ops accepted at edge k: result in wb_data, rd in wb_reg, wb_we = (rd != 0) from edge k until edge k+1; register file commits at edge k+1.
REQ-017 ADD: a+b mod 2^WIDTH, carry <= carry-out; SUB: a-b mod 2^WIDTH, carry <= borrow (a<b).
REQ-018 AND/OR/XOR: bitwise; SLL: a << b[1:0], zero fill; LI: result = zero-extended in_rs2 field, no register read used.
REQ-019 Only ADD and SUB update carry; all other ops leave it unchanged.
REQ-020 MUL accepted at edge k: operands latched (after forwarding), state -> MUL, 2-bit counter cleared; one shift-add iteration per edge k+1..k+4; at edge k+4 low WIDTH bits of product written to wb_data, wb_reg <= rd, wb_we <= (rd != 0), state -> IDLE.
REQ-021 wb_we is 0 on every edge where no op completes (including MUL iteration edges k+1..k+3), back-to-back single-cycle ops give wb_we high on consecutive cycles.
REQ-022 rd == 0: result computed, wb_we stays 0, no forwarding from it.
REQ-023 in_valid while in_ready = 0 is ignored, not queued; the driver holds the instruction.

Reset
REQ-024 rst_n low at a rising edge: state <= IDLE, counter <= 0, wb_we <= 0, wb_reg <= 0, wb_data <= 0, carry <= 0; reset dominates acceptance.
REQ-025 Reset mid-MUL aborts it: no write-back, in_ready = 1 in the cycle after reset deasserts.

Structure
REQ-026 Shared package alu_exec_pkg holds opcode constants and the IDLE/MUL state encoding.
REQ-027 Iterative multiplier is sub-module alu_exec_mul (start, operands, done, product); all other logic in alu_exec.

Verification
REQ-028 LI r1,5 then ADD r2,r1,r1 on consecutive edges -> second op forwarded; wb_we=1, wb_reg=2, wb_data=0xA, carry=0.
REQ-029 r1=9, r2=8; ADD r3,r1,r2 -> wb_data=0x1, carry=1; then AND r4,r1,r2 -> wb_data=0x8, carry remains 1.
REQ-030 r1=3, r2=5; SUB r3,r1,r2 -> wb_data=0xE, carry=1.
REQ-031 r1=3, r2=6; MUL r3,r1,r2 at edge k -> in_ready low and busy high for 4 cycles, wb_we high only after edge k+4, wb_data=0x2; new in_valid during MUL not accepted.
REQ-032 LI r0,7 -> wb_we stays 0; following ADD r1,r0,r0 -> wb_data=0x0.
REQ-033 rst_n low one cycle during MUL iteration 2 -> wb_we never asserts for that MUL, carry=0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec execution unit: opcodes, FSM states and
// the fixed iteration count of the iterative multiplier.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_LI  = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int unsigned MUL_ITERS = 4;

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative shift-add multiplier: operands latched on start, four iterations,
// done is asserted combinationally during the last one with the final product.
module alu_exec_mul
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  // Multiplier bits consumed per iteration so four iterations cover any WIDTH.
  localparam int unsigned STEP = (WIDTH + MUL_ITERS - 1) / MUL_ITERS;

  logic             run;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (mplier[j]) acc_next = acc_next + (mcand << j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << STEP;
      mplier <= mplier >> STEP;
      cnt    <= cnt + 2'd1;
      if (cnt == 2'd3) run <= 1'b0;
    end
  end

  assign done    = run && (cnt == 2'd3);
  assign product = acc_next;

endmodule

// File: rtl/alu_exec.sv
// Single-issue execution unit: single-cycle ALU ops with write-back forwarding
// plus a 4-iteration multiplier that stalls issue while it runs.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs1,
  input  logic [2:0]       in_rs2,
  output logic [2:0]       rf_raddr1,
  output logic [2:0]       rf_raddr2,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  output logic             wb_we,
  output logic [2:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             carry,
  output logic             busy
);

  state_t           state, state_next;
  op_t              op;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] op_a, op_b, alu_res, mul_prod;
  logic             alu_carry, carry_upd;
  logic [2:0]       mul_rd;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // The pending write-back has not reached the register file yet; bypass it.
  assign op_a = (wb_we && wb_reg == in_rs1) ? wb_data : rf_rdata1;
  assign op_b = (wb_we && wb_reg == in_rs2) ? wb_data : rf_rdata2;

  assign op        = op_t'(in_op);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_MUL);
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    carry_upd = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
        carry_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
        carry_upd = 1'b1;
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[1:0];
      OP_LI:   alu_res = WIDTH'(in_rs2);
      default: alu_res = '0;
    endcase
  end

  alu_exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
      carry   <= 1'b0;
      mul_rd  <= '0;
    end else begin
      wb_we <= 1'b0;
      if (accept && op != OP_MUL) begin
        wb_data <= alu_res;
        wb_reg  <= in_rd;
        wb_we   <= (in_rd != 3'd0);
        if (carry_upd) carry <= alu_carry;
      end else if (mul_start) begin
        mul_rd <= in_rd;
      end else if (state == ST_MUL && mul_done) begin
        wb_data <= mul_prod;
        wb_reg  <= mul_rd;
        wb_we   <= (mul_rd != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboarded bench for alu_exec: an architectural model predicts each
// write-back at issue time; a negedge monitor pops and compares.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]   rf_raddr1, rf_raddr2;
  logic [W-1:0] rf_rdata1, rf_rdata2;
  logic         wb_we;
  logic [2:0]   wb_reg;
  logic [W-1:0] wb_data;
  logic         carry, busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0]   rd;
    logic [W-1:0] data;
    logic         c;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] rf       [8] = '{default: '0};
  logic [W-1:0] model_rf [8] = '{default: '0};
  logic         model_c = 1'b0;
  logic         pre_we = 1'b0;
  logic [2:0]   pre_idx = '0;
  logic [W-1:0] pre_val = '0;

  alu_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .carry     (carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge clk) begin
    if (wb_we)  rf[wb_reg]  <= wb_data;
    if (pre_we) rf[pre_idx] <= pre_val;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wb_we === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_wb: wb_reg=%0d wb_data=%h, required no write-back", wb_reg, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_reg !== e.rd || wb_data !== e.data || carry !== e.c) begin
          fails++;
          $display("FAIL sb_wb: got reg=%0d data=%h carry=%b, required reg=%0d data=%h carry=%b",
                   wb_reg, wb_data, carry, e.rd, e.data, e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_exec(input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2);
    logic [W-1:0]   a, b, r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    a = model_rf[rs1];
    b = model_rf[rs2];
    case (op_t'(op))
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; model_c = s[W]; end
      OP_SUB: begin r = a - b; model_c = (a < b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << b[1:0];
      OP_LI:  r = W'(rs2);
      default: begin p = a * b; r = p[W-1:0]; end
    endcase
    if (rd != 3'd0) begin
      model_rf[rd] = r;
      sb.push_back('{rd: rd, data: r, c: model_c});
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    int unsigned n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_exec(op, rd, rs1, rs2);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%b, required 0 and 1", sb.size(), in_ready);
    end
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [W-1:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    model_rf[idx] = val;
    #1 pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({wb_we, wb_reg, wb_data, carry, in_ready, busy} !== {1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: we=%b reg=%0d data=%h carry=%b ready=%b busy=%b, required 0 0 0 0 1 0",
               wb_we, wb_reg, wb_data, carry, in_ready, busy);
    end
    in_rs1 = 3'd5; in_rs2 = 3'd3;
    #1;
    tests++;
    if (rf_raddr1 !== 3'd5 || rf_raddr2 !== 3'd3) begin
      fails++;
      $display("FAIL raddr: got %0d/%0d, required 5/3", rf_raddr1, rf_raddr2);
    end
    rst_n = 1'b1;
    model_c = 1'b0;
  endtask

  task automatic test_forward();
    issue(OP_LI, 3'd1, 3'd0, 3'd5);
    issue(OP_ADD, 3'd2, 3'd1, 3'd1);
    @(negedge clk);
    tests++;
    if (wb_we !== 1'b1 || wb_reg !== 3'd2 || wb_data !== 4'hA || carry !== 1'b0) begin
      fails++;
      $display("FAIL forward: we=%b reg=%0d data=%h carry=%b, required 1 2 a 0", wb_we, wb_reg, wb_data, carry);
    end
    drain();
  endtask

  task automatic test_carry();
    set_reg(3'd1, 4'd9);
    set_reg(3'd2, 4'd8);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    tests++;
    if (wb_data !== 4'h1 || carry !== 1'b1) begin
      fails++;
      $display("FAIL add_carry: data=%h carry=%b, required 1 1", wb_data, carry);
    end
    issue(OP_AND, 3'd4, 3'd1, 3'd2);
    @(negedge clk);
    tests++;
    if (wb_data !== 4'h8 || carry !== 1'b1) begin
      fails++;
      $display("FAIL and_keep_carry: data=%h carry=%b, required 8 1", wb_data, carry);
    end
    drain();
  endtask

  task automatic test_sub();
    set_reg(3'd1, 4'd3);
    set_reg(3'd2, 4'd5);
    issue(OP_SUB, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    tests++;
    if (wb_data !== 4'hE || carry !== 1'b1) begin
      fails++;
      $display("FAIL sub_borrow: data=%h carry=%b, required e 1", wb_data, carry);
    end
    drain();
  endtask

  task automatic test_mul();
    set_reg(3'd1, 4'd3);
    set_reg(3'd2, 4'd6);
    issue(OP_MUL, 3'd3, 3'd1, 3'd2);
    in_valid = 1'b1; in_op = OP_LI; in_rd = 3'd5; in_rs1 = 3'd0; in_rs2 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || wb_we !== 1'b0) begin
        fails++;
        $display("FAIL mul_busy[%0d]: ready=%b busy=%b we=%b, required 0 1 0", i, in_ready, busy, wb_we);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (wb_we !== 1'b1 || wb_reg !== 3'd3 || wb_data !== 4'h2 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mul_done: we=%b reg=%0d data=%h ready=%b busy=%b, required 1 3 2 1 0",
               wb_we, wb_reg, wb_data, in_ready, busy);
    end
    @(negedge clk);
    tests++;
    if (wb_we !== 1'b0) begin
      fails++;
      $display("FAIL mul_stall_drop: we=%b, required 0", wb_we);
    end
    drain();
  endtask

  task automatic test_r0();
    issue(OP_LI, 3'd0, 3'd0, 3'd7);
    @(negedge clk);
    tests++;
    if (wb_we !== 1'b0) begin
      fails++;
      $display("FAIL r0_no_we: we=%b, required 0", wb_we);
    end
    issue(OP_ADD, 3'd1, 3'd0, 3'd0);
    @(negedge clk);
    tests++;
    if (wb_we !== 1'b1 || wb_reg !== 3'd1 || wb_data !== 4'h0) begin
      fails++;
      $display("FAIL r0_no_fwd: we=%b reg=%0d data=%h, required 1 1 0", wb_we, wb_reg, wb_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    set_reg(3'd1, 4'd9);
    set_reg(3'd2, 4'd8);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    drain();
    set_reg(3'd1, 4'd3);
    set_reg(3'd2, 4'd6);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MUL; in_rd = 3'd4; in_rs1 = 3'd1; in_rs2 = 3'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_c = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || carry !== 1'b0 || wb_we !== 1'b0) begin
      fails++;
      $display("FAIL mul_abort: ready=%b busy=%b carry=%b we=%b, required 1 0 0 0", in_ready, busy, carry, wb_we);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (wb_we !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL mul_abort_quiet[%0d]: we=%b ready=%b, required 0 1", i, wb_we, in_ready);
      end
    end
    issue(OP_ADD, 3'd5, 3'd1, 3'd2);
    drain();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_carry();
    test_sub();
    test_mul();
    test_r0();
    test_back_to_back();
    test_reset_mid_mul();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: pending=%0d, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
